// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: decode/EX/MEM status into the controller,
// stall/bubble/flush/error/perf controls back out to the pipeline.
//   master: pipeline side (drives *_i, reads *_o)
//   slave : hazard_ctrl side (reads *_i, drives *_o)
`ifndef REG_IDX_WIDTH
`define REG_IDX_WIDTH 5
`endif

interface hazard_ctrl_if;
    logic                      id_valid_i;
    logic [`REG_IDX_WIDTH-1:0] dec_rs1_idx_i;
    logic [`REG_IDX_WIDTH-1:0] dec_rs2_idx_i;
    logic                      dec_rs1_en_i;
    logic                      dec_rs2_en_i;
    logic [`REG_IDX_WIDTH-1:0] dec_rd_idx_i;
    logic                      dec_rd_en_i;
    logic                      dec_is_load_i;
    logic                      ex_jump_i;
    logic                      mem_busy_i;
    logic                      stall_pc_o;
    logic                      stall_if_id_o;
    logic                      stall_id_ex_o;
    logic                      bubble_id_ex_o;
    logic                      flush_if_id_o;
    logic                      err_timeout_o;
    logic [31:0]               perf_stall_cnt_o;
    logic [31:0]               perf_flush_cnt_o;

    modport master (
        output id_valid_i, dec_rs1_idx_i, dec_rs2_idx_i,
        output dec_rs1_en_i, dec_rs2_en_i, dec_rd_idx_i,
        output dec_rd_en_i, dec_is_load_i, ex_jump_i, mem_busy_i,
        input  stall_pc_o, stall_if_id_o, stall_id_ex_o,
        input  bubble_id_ex_o, flush_if_id_o, err_timeout_o,
        input  perf_stall_cnt_o, perf_flush_cnt_o
    );

    modport slave (
        input  id_valid_i, dec_rs1_idx_i, dec_rs2_idx_i,
        input  dec_rs1_en_i, dec_rs2_en_i, dec_rd_idx_i,
        input  dec_rd_en_i, dec_is_load_i, ex_jump_i, mem_busy_i,
        output stall_pc_o, stall_if_id_o, stall_id_ex_o,
        output bubble_id_ex_o, flush_if_id_o, err_timeout_o,
        output perf_stall_cnt_o, perf_flush_cnt_o
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, memory-wait freeze,
// jump flush (deferred while memory is busy) and memory timeout watchdog.
// Ports: clk, rst (sync, active-high), bus (hazard_ctrl_if.slave).
// Optional macro HAZARD_CTRL_PERF_EN adds stall/flush event counters;
// without it the perf outputs are tied to zero.
`ifndef REG_IDX_WIDTH
`define REG_IDX_WIDTH 5
`endif
`ifndef REG_X0
`define REG_X0 {`REG_IDX_WIDTH{1'b0}}
`endif

module hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  bus
);
    localparam logic [15:0] TIMEOUT = 16'(MEM_TIMEOUT);

    typedef enum logic [1:0] {S_RUN, S_WAIT, S_WAIT_F} state_t;

    state_t                    state_q, state_d;
    logic                      ld_vld_q, ld_vld_d;
    logic [`REG_IDX_WIDTH-1:0] ld_rd_q, ld_rd_d;
    logic [15:0]               wd_q, wd_d;
    logic                      err_q, err_d;

    logic rs1_hit, rs2_hit, load_use, do_flush;
    logic stall_pc, stall_if_id, stall_id_ex, bubble, flush;

    assign rs1_hit = bus.dec_rs1_en_i && (bus.dec_rs1_idx_i != `REG_X0)
                  && (bus.dec_rs1_idx_i == ld_rd_q);
    assign rs2_hit = bus.dec_rs2_en_i && (bus.dec_rs2_idx_i != `REG_X0)
                  && (bus.dec_rs2_idx_i == ld_rd_q);

    // State-derived requests are masked in reset so outputs read 0 there.
    assign load_use = ~rst & bus.id_valid_i & ld_vld_q & (rs1_hit | rs2_hit);
    assign do_flush = bus.ex_jump_i | (~rst & (state_q == S_WAIT_F));

    always_comb begin
        stall_pc    = 1'b0;
        stall_if_id = 1'b0;
        stall_id_ex = 1'b0;
        bubble      = 1'b0;
        flush       = 1'b0;
        if (bus.mem_busy_i) begin
            stall_pc    = 1'b1;
            stall_if_id = 1'b1;
            stall_id_ex = 1'b1;
        end else if (do_flush) begin
            flush  = 1'b1;
            bubble = 1'b1;
        end else if (load_use) begin
            stall_pc    = 1'b1;
            stall_if_id = 1'b1;
            bubble      = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_RUN: begin
                if (bus.mem_busy_i)
                    state_d = bus.ex_jump_i ? S_WAIT_F : S_WAIT;
            end
            S_WAIT: begin
                if (!bus.mem_busy_i)    state_d = S_RUN;
                else if (bus.ex_jump_i) state_d = S_WAIT_F;
            end
            S_WAIT_F: begin
                if (!bus.mem_busy_i) state_d = S_RUN;
            end
            default: state_d = S_RUN;
        endcase
    end

    // Tracker follows ID_EX: it only advances when ID_EX is not held.
    always_comb begin
        ld_vld_d = ld_vld_q;
        ld_rd_d  = ld_rd_q;
        if (!stall_id_ex) begin
            ld_vld_d = bus.id_valid_i & bus.dec_is_load_i & bus.dec_rd_en_i
                     & (bus.dec_rd_idx_i != `REG_X0) & ~bubble & ~flush;
            ld_rd_d  = bus.dec_rd_idx_i;
        end
    end

    always_comb begin
        wd_d = 16'd0;
        if (bus.mem_busy_i)
            wd_d = (wd_q == 16'hFFFF) ? wd_q : wd_q + 16'd1;
        err_d = err_q | (wd_d >= TIMEOUT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_RUN;
            ld_vld_q <= 1'b0;
            ld_rd_q  <= `REG_X0;
            wd_q     <= 16'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ld_vld_q <= ld_vld_d;
            ld_rd_q  <= ld_rd_d;
            wd_q     <= wd_d;
            err_q    <= err_d;
        end
    end

`ifdef HAZARD_CTRL_PERF_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            if (stall_pc && stall_cnt_q != 32'hFFFF_FFFF)
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (flush && flush_cnt_q != 32'hFFFF_FFFF)
                flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign bus.perf_stall_cnt_o = stall_cnt_q;
    assign bus.perf_flush_cnt_o = flush_cnt_q;
`else
    assign bus.perf_stall_cnt_o = 32'h0;
    assign bus.perf_flush_cnt_o = 32'h0;
`endif

    assign bus.stall_pc_o     = stall_pc;
    assign bus.stall_if_id_o  = stall_if_id;
    assign bus.stall_id_ex_o  = stall_id_ex;
    assign bus.bubble_id_ex_o = bubble;
    assign bus.flush_if_id_o  = flush;
    assign bus.err_timeout_o  = err_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl (MEM_TIMEOUT=8).
// ctl = {stall_pc, stall_if_id, stall_id_ex, bubble, flush}.
module tb_hazard_ctrl;
    logic clk;
    logic rst;
    int   vecs;
    int   errs;

`ifdef HAZARD_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    hazard_ctrl_if bus ();

    hazard_ctrl #(.MEM_TIMEOUT(8)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [4:0] ctl;
    assign ctl = {bus.stall_pc_o, bus.stall_if_id_o, bus.stall_id_ex_o,
                  bus.bubble_id_ex_o, bus.flush_if_id_o};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.id_valid_i    = 1'b0;
        bus.dec_rs1_idx_i = '0;
        bus.dec_rs2_idx_i = '0;
        bus.dec_rs1_en_i  = 1'b0;
        bus.dec_rs2_en_i  = 1'b0;
        bus.dec_rd_idx_i  = '0;
        bus.dec_rd_en_i   = 1'b0;
        bus.dec_is_load_i = 1'b0;
        bus.ex_jump_i     = 1'b0;
        bus.mem_busy_i    = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
    endtask

    task automatic set_load(input logic [4:0] rd, input logic [4:0] rs1);
        idle();
        bus.id_valid_i    = 1'b1;
        bus.dec_is_load_i = 1'b1;
        bus.dec_rd_en_i   = 1'b1;
        bus.dec_rd_idx_i  = rd;
        bus.dec_rs1_idx_i = rs1;
        bus.dec_rs1_en_i  = (rs1 != 5'd0);
    endtask

    task automatic set_use(input logic [4:0] r1, input logic e1,
                           input logic [4:0] r2, input logic e2);
        idle();
        bus.id_valid_i    = 1'b1;
        bus.dec_rd_en_i   = 1'b1;
        bus.dec_rd_idx_i  = 5'd10;
        bus.dec_rs1_idx_i = r1;
        bus.dec_rs1_en_i  = e1;
        bus.dec_rs2_idx_i = r2;
        bus.dec_rs2_en_i  = e2;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        tick();
        #2;
        vecs++;
        if (ctl !== 5'b00000) begin
            errs++;
            $display("FAIL rst_ctl got %b want %b", ctl, 5'b00000);
        end
        vecs++;
        if (bus.err_timeout_o !== 1'b0) begin
            errs++;
            $display("FAIL rst_err got %b want 0", bus.err_timeout_o);
        end
        vecs++;
        if (bus.perf_stall_cnt_o !== 32'd0 || bus.perf_flush_cnt_o !== 32'd0) begin
            errs++;
            $display("FAIL rst_perf got %0d/%0d want 0/0",
                     bus.perf_stall_cnt_o, bus.perf_flush_cnt_o);
        end
        tick();
        rst = 1'b0;
        tick();
        #2;
        vecs++;
        if (ctl !== 5'b00000) begin
            errs++;
            $display("FAIL post_rst_ctl got %b want %b", ctl, 5'b00000);
        end
        tick();
    endtask

    task automatic test_load_use();
        do_reset();
        set_load(5'd5, 5'd0);
        #2;
        vecs++;
        if (ctl !== 5'b00000) begin
            errs++;
            $display("FAIL lu_load got %b want %b", ctl, 5'b00000);
        end
        tick();
        set_use(5'd5, 1'b1, 5'd0, 1'b0);
        #2;
        vecs++;
        if (ctl !== 5'b11010) begin
            errs++;
            $display("FAIL lu_stall got %b want %b", ctl, 5'b11010);
        end
        tick();
        #2;
        vecs++;
        if (ctl !== 5'b00000) begin
            errs++;
            $display("FAIL lu_release got %b want %b", ctl, 5'b00000);
        end
        tick();
    endtask

    task automatic test_no_dep();
        do_reset();
        set_load(5'd0, 5'd0);
        tick();
        set_use(5'd0, 1'b1, 5'd0, 1'b0);
        #2;
        vecs++;
        if (ctl !== 5'b00000) begin
            errs++;
            $display("FAIL x0_dep got %b want %b", ctl, 5'b00000);
        end
        tick();
        set_load(5'd5, 5'd0);
        tick();
        set_use(5'd3, 1'b0, 5'd5, 1'b0);
        #2;
        vecs++;
        if (ctl !== 5'b00000) begin
            errs++;
            $display("FAIL rs2_dis got %b want %b", ctl, 5'b00000);
        end
        tick();
        set_load(5'd7, 5'd0);
        tick();
        set_use(5'd3, 1'b0, 5'd7, 1'b1);
        #2;
        vecs++;
        if (ctl !== 5'b11010) begin
            errs++;
            $display("FAIL rs2_hit got %b want %b", ctl, 5'b11010);
        end
        tick();
    endtask

    task automatic test_mem_wait();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            bus.mem_busy_i = 1'b1;
            #2;
            vecs++;
            if (ctl !== 5'b11100) begin
                errs++;
                $display("FAIL mw_busy%0d got %b want %b", i, ctl, 5'b11100);
            end
            tick();
        end
        bus.mem_busy_i = 1'b0;
        #2;
        vecs++;
        if (ctl !== 5'b00000) begin
            errs++;
            $display("FAIL mw_done got %b want %b", ctl, 5'b00000);
        end
        vecs++;
        if (bus.perf_stall_cnt_o !== (PERF ? 32'd4 : 32'd0)) begin
            errs++;
            $display("FAIL mw_perf got %0d want %0d",
                     bus.perf_stall_cnt_o, PERF ? 4 : 0);
        end
        tick();
    endtask

    task automatic test_jump_in_wait();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            bus.mem_busy_i = 1'b1;
            bus.ex_jump_i  = (i == 1);
            #2;
            vecs++;
            if (ctl !== 5'b11100) begin
                errs++;
                $display("FAIL jw_busy%0d got %b want %b", i, ctl, 5'b11100);
            end
            tick();
        end
        bus.mem_busy_i = 1'b0;
        bus.ex_jump_i  = 1'b0;
        #2;
        vecs++;
        if (ctl !== 5'b00011) begin
            errs++;
            $display("FAIL jw_flush got %b want %b", ctl, 5'b00011);
        end
        tick();
        #2;
        vecs++;
        if (ctl !== 5'b00000) begin
            errs++;
            $display("FAIL jw_after got %b want %b", ctl, 5'b00000);
        end
        vecs++;
        if (bus.perf_flush_cnt_o !== (PERF ? 32'd1 : 32'd0)) begin
            errs++;
            $display("FAIL jw_perf got %0d want %0d",
                     bus.perf_flush_cnt_o, PERF ? 1 : 0);
        end
        tick();
    endtask

    task automatic test_flush_vs_lu();
        do_reset();
        set_load(5'd5, 5'd0);
        tick();
        set_use(5'd5, 1'b1, 5'd0, 1'b0);
        bus.ex_jump_i = 1'b1;
        #2;
        vecs++;
        if (ctl !== 5'b00011) begin
            errs++;
            $display("FAIL fl_vs_lu got %b want %b", ctl, 5'b00011);
        end
        tick();
        idle();
        #2;
        vecs++;
        if (ctl !== 5'b00000) begin
            errs++;
            $display("FAIL fl_after got %b want %b", ctl, 5'b00000);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_load(5'd5, 5'd0);
        tick();
        set_load(5'd6, 5'd1);
        tick();
        set_use(5'd5, 1'b1, 5'd0, 1'b0);
        #2;
        vecs++;
        if (ctl !== 5'b00000) begin
            errs++;
            $display("FAIL b2b_far got %b want %b", ctl, 5'b00000);
        end
        tick();
        set_load(5'd5, 5'd0);
        tick();
        set_load(5'd6, 5'd1);
        tick();
        set_use(5'd5, 1'b1, 5'd6, 1'b1);
        #2;
        vecs++;
        if (ctl !== 5'b11010) begin
            errs++;
            $display("FAIL b2b_adj got %b want %b", ctl, 5'b11010);
        end
        tick();
        #2;
        vecs++;
        if (ctl !== 5'b00000) begin
            errs++;
            $display("FAIL b2b_rel got %b want %b", ctl, 5'b00000);
        end
        tick();
    endtask

    task automatic test_timeout();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            bus.mem_busy_i = 1'b1;
            #2;
            vecs++;
            if (bus.err_timeout_o !== 1'b0) begin
                errs++;
                $display("FAIL to_early%0d got %b want 0", i, bus.err_timeout_o);
            end
            tick();
        end
        bus.mem_busy_i = 1'b0;
        #2;
        vecs++;
        if (bus.err_timeout_o !== 1'b1) begin
            errs++;
            $display("FAIL to_set got %b want 1", bus.err_timeout_o);
        end
        tick();
        #2;
        vecs++;
        if (bus.err_timeout_o !== 1'b1) begin
            errs++;
            $display("FAIL to_sticky got %b want 1", bus.err_timeout_o);
        end
        tick();
        bus.mem_busy_i = 1'b1;
        bus.ex_jump_i  = 1'b1;
        tick();
        bus.ex_jump_i  = 1'b0;
        tick();
        rst = 1'b1;
        bus.mem_busy_i = 1'b0;
        #2;
        vecs++;
        if (ctl !== 5'b00000) begin
            errs++;
            $display("FAIL to_rst_ctl got %b want %b", ctl, 5'b00000);
        end
        tick();
        #2;
        vecs++;
        if (bus.err_timeout_o !== 1'b0 || bus.perf_stall_cnt_o !== 32'd0
            || bus.perf_flush_cnt_o !== 32'd0) begin
            errs++;
            $display("FAIL to_rst_clr got err=%b st=%0d fl=%0d want 0/0/0",
                     bus.err_timeout_o, bus.perf_stall_cnt_o,
                     bus.perf_flush_cnt_o);
        end
        rst = 1'b0;
        tick();
        #2;
        vecs++;
        if (ctl !== 5'b00000 || bus.err_timeout_o !== 1'b0) begin
            errs++;
            $display("FAIL to_run got %b/%b want %b/0",
                     ctl, bus.err_timeout_o, 5'b00000);
        end
        tick();
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        rst  = 1'b1;
        idle();
        test_reset();
        test_load_use();
        test_no_dep();
        test_mem_wait();
        test_jump_in_wait();
        test_flush_vs_lu();
        test_back_to_back();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
